// File: rtl/gshare_spec_history.sv
// Gshare PHT index generator with speculative/architectural global history and
// per-branch history checkpoints, so a mispredict restores history out of order.
module gshare_spec_history #(
   parameter int GHR_W  = 10,
   parameter int IDX_W  = 10,
   parameter int PC_W   = 32,
   parameter int PC_LSB = 2,
   parameter int DEPTH  = 4,
   localparam int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  fetch_pc,
   output logic [IDX_W-1:0] index,
   input  logic             predict_valid,
   input  logic             predict_taken,
   output logic             predict_ready,
   output logic [TAG_W-1:0] predict_tag,
   input  logic             commit_valid,
   input  logic             commit_taken,
   input  logic             mispredict_valid,
   input  logic [TAG_W-1:0] mispredict_tag,
   input  logic             mispredict_taken,
   input  logic             flush,
   output logic [GHR_W-1:0] spec_history
);

   localparam int PTR_W = TAG_W + 1;

   logic [GHR_W-1:0] sghr, aghr;
   logic [GHR_W-1:0] ckpt [DEPTH];
   logic [PTR_W-1:0] head, tail, head_nx, count, mp_ptr;
   logic [TAG_W-1:0] mp_off;
   logic             full, empty, accept, do_commit, mp_live;
   logic [GHR_W-1:0] aghr_shift, aghr_nx, sghr_pred, sghr_restore, ckpt_sel;
   logic [IDX_W-1:0] hist;
   logic             unused_pc;

   assign full          = (head[TAG_W-1:0] == tail[TAG_W-1:0]) && (head[TAG_W] != tail[TAG_W]);
   assign empty         = (head == tail);
   assign predict_ready = !full;
   assign predict_tag   = tail[TAG_W-1:0];
   assign spec_history  = sghr;

   assign accept    = predict_valid && !full && !mispredict_valid && !flush;
   assign do_commit = commit_valid && !empty;
   assign head_nx   = do_commit ? head + PTR_W'(1) : head;
   assign aghr_nx   = do_commit ? aghr_shift : aghr;

   // Rebuild the full pointer of the mispredicted entry from its distance to head,
   // which recovers the correct wrap bit.
   assign count    = tail - head;
   assign mp_off   = mispredict_tag - head[TAG_W-1:0];
   assign mp_ptr   = head + {1'b0, mp_off};
   assign mp_live  = {1'b0, mp_off} < count;
   assign ckpt_sel = ckpt[mispredict_tag];

   generate
      if (GHR_W == 1) begin : g_load
         assign sghr_pred    = predict_taken;
         assign sghr_restore = mispredict_taken;
         assign aghr_shift   = commit_taken;
      end else begin : g_shift
         assign sghr_pred    = {sghr[GHR_W-2:0], predict_taken};
         assign sghr_restore = {ckpt_sel[GHR_W-2:0], mispredict_taken};
         assign aghr_shift   = {aghr[GHR_W-2:0], commit_taken};
      end

      if (GHR_W >= IDX_W) begin : g_hist_trunc
         assign hist = sghr[IDX_W-1:0];
      end else begin : g_hist_ext
         assign hist = {{(IDX_W-GHR_W){1'b0}}, sghr};
      end
   endgenerate

   assign index     = fetch_pc[PC_LSB +: IDX_W] ^ hist;
   assign unused_pc = ^fetch_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         sghr <= '0;
         aghr <= '0;
         head <= '0;
         tail <= '0;
      end else begin
         aghr <= aghr_nx;
         head <= head_nx;
         if (flush) begin
            sghr <= aghr_nx;
            tail <= head_nx;
         end else if (mispredict_valid) begin
            sghr <= sghr_restore;
            tail <= mp_ptr + PTR_W'(1);
         end else if (accept) begin
            sghr <= sghr_pred;
            tail <= tail + PTR_W'(1);
         end

         assert (!(commit_valid && empty));
         assert (!(mispredict_valid && !flush && !mp_live));
         assert (!(commit_valid && mispredict_valid && !empty &&
                   mispredict_tag == head[TAG_W-1:0]));
      end
   end

   // Checkpoint holds the history as it was before this branch's own update.
   always_ff @(posedge clk) begin
      if (accept) ckpt[tail[TAG_W-1:0]] <= sghr;
   end

endmodule

// File: tb/tb_gshare_spec_history.sv
// Randomized and directed check of gshare_spec_history against a queue-based
// model of in-flight branches and their saved histories.
module tb_gshare_spec_history;

   localparam int DEPTH = 4;
   localparam int HMASK = 'h3FF;

   logic        clk = 0;
   logic        reset = 1;
   logic [31:0] fetch_pc = 32'h0000_0ABC;
   logic [9:0]  index;
   logic        predict_valid = 0, predict_taken = 0, predict_ready;
   logic [1:0]  predict_tag;
   logic        commit_valid = 0, commit_taken = 0;
   logic        mispredict_valid = 0, mispredict_taken = 0;
   logic [1:0]  mispredict_tag = 0;
   logic        flush = 0;
   logic [9:0]  spec_history;

   gshare_spec_history dut (
      .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .index(index),
      .predict_valid(predict_valid), .predict_taken(predict_taken),
      .predict_ready(predict_ready), .predict_tag(predict_tag),
      .commit_valid(commit_valid), .commit_taken(commit_taken),
      .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
      .mispredict_taken(mispredict_taken), .flush(flush),
      .spec_history(spec_history)
   );

   always #5 clk = ~clk;

   typedef struct {int tag; int ck;} ent_t;
   ent_t q[$];
   int m_sghr = 0, m_aghr = 0, head_tag = 0, tail_tag = 0;
   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int shl(input int v, input logic b);
      return ((v << 1) | int'(b)) & HMASK;
   endfunction

   function automatic void model_update();
      int sz0 = q.size();
      if (reset) begin
         q.delete();
         m_sghr = 0; m_aghr = 0; head_tag = 0; tail_tag = 0;
         return;
      end
      if (commit_valid && sz0 > 0) begin
         m_aghr = shl(m_aghr, commit_taken);
         void'(q.pop_front());
         head_tag = (head_tag + 1) % DEPTH;
      end
      if (flush) begin
         q.delete();
         m_sghr = m_aghr;
         tail_tag = head_tag;
      end else if (mispredict_valid) begin
         int k = 0;
         for (int i = 0; i < q.size(); i++) if (q[i].tag == int'(mispredict_tag)) k = i;
         while (q.size() > k + 1) void'(q.pop_back());
         m_sghr = shl(q[k].ck, mispredict_taken);
         tail_tag = (int'(mispredict_tag) + 1) % DEPTH;
      end else if (predict_valid && sz0 < DEPTH) begin
         q.push_back('{tail_tag, m_sghr});
         m_sghr = shl(m_sghr, predict_taken);
         tail_tag = (tail_tag + 1) % DEPTH;
      end
   endfunction

   task automatic drive(input logic pv, pt, cv, ct, mv, input int mtag,
                        input logic mt, fl, rs);
      @(negedge clk);
      predict_valid = pv; predict_taken = pt;
      commit_valid = cv; commit_taken = ct;
      mispredict_valid = mv; mispredict_tag = 2'(mtag); mispredict_taken = mt;
      flush = fl; reset = rs;
      #1;
      chk("index", 32'(index), 32'(((fetch_pc >> 2) ^ 32'(m_sghr)) & HMASK));
      chk("ready", 32'(predict_ready), 32'(q.size() < DEPTH));
      chk("tag", 32'(predict_tag), 32'(tail_tag));
      chk("spec_history", 32'(spec_history), 32'(m_sghr));
      @(posedge clk);
      model_update();
      #1;
      predict_valid = 0; commit_valid = 0; mispredict_valid = 0; flush = 0; reset = 0;
   endtask

   task automatic pred(input logic t);              drive(1, t, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic cmt(input logic t);               drive(0, 0, 1, t, 0, 0, 0, 0, 0); endtask
   task automatic mis(input int tg, input logic t); drive(0, 0, 0, 0, 1, tg, t, 0, 0); endtask
   task automatic do_flush();                       drive(0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
   task automatic do_reset();                       drive(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic peek(); @(negedge clk); #1; endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 0;

      // Reset values and base index
      peek();
      chk("rst_index", 32'(index), 32'h2AF);
      chk("rst_ready", 32'(predict_ready), 32'd1);
      chk("rst_spec", 32'(spec_history), 32'h000);
      chk("rst_tag", 32'(predict_tag), 32'd0);

      // T,T,N -> tags 0,1,2, history 0x006
      pred(1); peek(); chk("tag_after1", 32'(predict_tag), 32'd1);
      pred(1); peek(); chk("tag_after2", 32'(predict_tag), 32'd2);
      pred(0); peek();
      chk("ttn_spec", 32'(spec_history), 32'h006);
      chk("ttn_index", 32'(index), 32'h2A9);

      // Mispredict tag1 actual N -> 0x002, next tag 2
      mis(1, 0); peek();
      chk("mp_spec", 32'(spec_history), 32'h002);
      chk("mp_tag", 32'(predict_tag), 32'd2);

      // Fill, overflow, drain one
      do_reset();
      pred(1); pred(0); pred(1); pred(1); peek();
      chk("full_ready", 32'(predict_ready), 32'd0);
      chk("full_spec", 32'(spec_history), 32'h00B);
      pred(1); peek();
      chk("ovf_spec", 32'(spec_history), 32'h00B);
      cmt(1); peek();
      chk("drain_ready", 32'(predict_ready), 32'd1);
      chk("drain_tag", 32'(predict_tag), 32'd0);

      // Commit T,T then flush with one in flight
      do_reset();
      pred(1); pred(1); pred(0); cmt(1); cmt(1); do_flush(); peek();
      chk("flush_spec", 32'(spec_history), 32'h003);
      chk("flush_ready", 32'(predict_ready), 32'd1);
      chk("flush_tag", 32'(predict_tag), 32'd2);

      // Same-cycle predict + mispredict: predict dropped
      do_reset();
      pred(1); pred(1);
      drive(1, 1, 0, 0, 1, 0, 1, 0, 0); peek();
      chk("pm_spec", 32'(spec_history), 32'h001);
      chk("pm_tag", 32'(predict_tag), 32'd1);

      // Reset mid-burst
      pred(1); pred(0);
      drive(1, 1, 1, 1, 0, 0, 0, 0, 1); peek();
      chk("mid_rst_spec", 32'(spec_history), 32'h000);
      chk("mid_rst_ready", 32'(predict_ready), 32'd1);
      chk("mid_rst_tag", 32'(predict_tag), 32'd0);
      chk("mid_rst_index", 32'(index), 32'h2AF);

      // Randomized legal traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic pv, pt, cv, ct, mv, mt, fl, rs;
         int mtag;
         fetch_pc = $urandom();
         pv = ($urandom_range(0, 3) != 0);
         pt = 1'($urandom_range(0, 1));
         cv = (q.size() > 0) && ($urandom_range(0, 1) == 0);
         ct = 1'($urandom_range(0, 1));
         mv = (q.size() > 0) && ($urandom_range(0, 7) == 0);
         mt = 1'($urandom_range(0, 1));
         mtag = 0;
         if (mv) begin
            mtag = q[$urandom_range(0, q.size() - 1)].tag;
            if (cv && mtag == q[0].tag) cv = 0;
         end
         fl = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 99) == 0);
         drive(pv, pt, cv, ct, mv, mtag, mt, fl, rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
